rdx2_fft_seq: RTL and testbench

- Sequencer (initiator) for the radix-2 DIF FFT datapath: walks every stage and butterfly of an N = 2^b_fftp point transform.
- Each enabled cycle it issues one twiddle angle index on Theta to the twiddle generator.
- The matching butterfly memory addresses, stage number and valid flag are delayed by the twiddle generator's latency. They therefore arrive at the butterfly aligned with Re/Im.
- Sits between the frame controller (Start/Done) and the butterfly/RAM datapath.

---
 rtl/rdx2_fft_seq.sv | 160 ++++++++++++++++
 tb/tb_rdx2_fft_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rdx2_fft_seq.sv
// Radix-2 DIF FFT sequencer: walks every stage/butterfly of an N = 2^b_fftp
// transform, issues the twiddle angle immediately and delays the butterfly
// addresses, stage number and flags by the twiddle generator latency.
module rdx2_fft_seq #(
  parameter int b_fftp    = 12,
  parameter int TWD_LAT   = 3,
  parameter int STAGE_GAP = 2,
  parameter int b_stg     = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ClockEn,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic [b_fftp-2:0] Theta,
  output logic [b_fftp-1:0] AddrA,
  output logic [b_fftp-1:0] AddrB,
  output logic [b_stg-1:0]  Stage,
  output logic              AddrValid,
  output logic              LastBfly
);

  localparam int CW = 16;

  typedef enum logic [2:0] {IDLE, RUN, GAP, DRAIN, FIN} state_t;

  state_t            state, state_nxt;
  logic [b_stg-1:0]  s, s_nxt;
  logic [b_fftp-2:0] k, k_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;

  logic              issue, last_k, last_s;
  logic [b_stg-1:0]  sh;
  logic [b_fftp-1:0] span, jv, gv, addr_a, addr_b;
  logic [b_fftp-2:0] theta_i;

  // Delay line for the address-side outputs; slot TWD_LAT-1 drives the ports.
  logic [b_fftp-1:0] pa [TWD_LAT];
  logic [b_fftp-1:0] pb [TWD_LAT];
  logic [b_stg-1:0]  ps [TWD_LAT];
  logic              pv [TWD_LAT];
  logic              pl [TWD_LAT];

  assign issue  = (state == RUN);
  assign last_k = &k;
  assign last_s = (s == b_stg'(b_fftp - 1));

  assign Busy      = (state != IDLE);
  assign Done      = (state == FIN);
  assign Theta     = issue ? theta_i : '0;
  assign AddrA     = pa[TWD_LAT-1];
  assign AddrB     = pb[TWD_LAT-1];
  assign Stage     = ps[TWD_LAT-1];
  assign AddrValid = pv[TWD_LAT-1];
  assign LastBfly  = pl[TWD_LAT-1];

  // Butterfly address and twiddle index for (s, k).
  // span is a power of two, so j = k mod span is a mask and AddrB = AddrA | span.
  always_comb begin
    sh      = b_stg'(b_fftp - 1) - s;
    span    = b_fftp'(1) << sh;
    jv      = {1'b0, k} & (span - b_fftp'(1));
    gv      = {1'b0, k} >> sh;
    addr_a  = (gv << (sh + b_stg'(1))) | jv;
    addr_b  = addr_a | span;
    theta_i = (b_fftp-1)'(jv << s);
  end

  // FSM state and stage/butterfly/idle counters.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      s     <= '0;
      k     <= '0;
      cnt   <= '0;
    end else if (ClockEn) begin
      state <= state_nxt;
      s     <= s_nxt;
      k     <= k_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: walk k within a stage, then gap or drain.
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    k_nxt     = k;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = RUN;
          s_nxt     = '0;
          k_nxt     = '0;
        end
      end
      RUN: begin
        k_nxt = k + (b_fftp-1)'(1);
        if (last_k) begin
          cnt_nxt = '0;
          if (last_s)              state_nxt = DRAIN;
          else if (STAGE_GAP == 0) s_nxt     = s + b_stg'(1);
          else                     state_nxt = GAP;
        end
      end
      GAP: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(STAGE_GAP - 1)) begin
          state_nxt = RUN;
          s_nxt     = s + b_stg'(1);
          k_nxt     = '0;
          cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(TWD_LAT - 1)) begin
          state_nxt = FIN;
          cnt_nxt   = '0;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Delay line; address fields only advance with a valid entry so the
  // outputs hold their last valid value through bubbles.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < unsigned'(TWD_LAT); i++) begin
        pa[i] <= '0;
        pb[i] <= '0;
        ps[i] <= '0;
        pv[i] <= 1'b0;
        pl[i] <= 1'b0;
      end
    end else if (ClockEn) begin
      pv[0] <= issue;
      pl[0] <= issue & last_k;
      if (issue) begin
        pa[0] <= addr_a;
        pb[0] <= addr_b;
        ps[0] <= s;
      end
      for (int unsigned i = 1; i < unsigned'(TWD_LAT); i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
        if (pv[i-1]) begin
          pa[i] <= pa[i-1];
          pb[i] <= pb[i-1];
          ps[i] <= ps[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_rdx2_fft_seq.sv
// Bench for rdx2_fft_seq: four configurations run in parallel, each with a
// transform-level reference model feeding a scoreboard and a negedge monitor.
module tb_rdx2_fft_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int a;
    int b;
    int s;
    bit last;
    int theta;
    bit first;
  } exp_t;

  task automatic chk(input string name, input int cfg, input longint got, input longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s cfg%0d: got %0d, want %0d", name, cfg, got, want);
    end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g
    localparam int B     = (gi == 2) ? 12 : (gi == 3) ? 4 : 3;
    localparam int L     = (gi == 3) ? 1 : 3;
    localparam int G     = (gi == 0) ? 0 : (gi == 3) ? 1 : 2;
    localparam int N     = 1 << B;
    localparam int HALF  = N / 2;
    localparam int T     = B * HALF + (B - 1) * G + L + 1;
    localparam int NRUNS = (B == 12) ? 2 : 5;
    localparam int LIM   = 8 * T + 100;

    logic         rst, en, start, busy, done, av, lb;
    logic [B-2:0] theta;
    logic [B-1:0] aa, ab;
    logic [3:0]   stg;
    bit           fin = 1'b0;

    rdx2_fft_seq #(.b_fftp(B), .TWD_LAT(L), .STAGE_GAP(G), .b_stg(4)) dut (
      .Clock(clk), .Reset(rst), .ClockEn(en), .Start(start),
      .Busy(busy), .Done(done), .Theta(theta), .AddrA(aa), .AddrB(ab),
      .Stage(stg), .AddrValid(av), .LastBfly(lb)
    );

    exp_t q[$];
    bit   m_busy = 1'b0;
    int   m_cnt  = 0;

    int          hist[$];
    int          ctl_err = 0, sb_err = 0, frz_err = 0, idle_err = 0, ab_err = 0, dup_err = 0;
    int          vcount = 0, cov_total = 0, max_th0 = 0, th;
    bit          cov [B][N];
    bit          have_prev = 1'b0, prev_en = 1'b0;
    logic [63:0] snap, prev_snap;
    exp_t        e;

    // Whole transform in stage / group / offset order.
    task automatic push_transform();
      for (int s = 0; s < B; s++) begin
        int span = N >> (s + 1);
        int idx  = 0;
        for (int grp = 0; grp < N / (2 * span); grp++) begin
          for (int j = 0; j < span; j++) begin
            exp_t x;
            x.a     = grp * 2 * span + j;
            x.b     = x.a + span;
            x.s     = s;
            x.last  = (idx == HALF - 1);
            x.theta = j * (N / (2 * span));
            x.first = (s == 0 && idx == 0);
            q.push_back(x);
            idx++;
          end
        end
      end
    endtask

    task automatic run_end_checks();
      chk("valid_count", gi, vcount, B * HALF);
      chk("stage_coverage", gi, cov_total, B * N);
      chk("max_theta_stage0", gi, max_th0, HALF - 1);
      chk("queue_empty_at_done", gi, q.size(), 0);
    endtask

    // Reference model: transform acceptance and enabled-cycle count to Done.
    always @(posedge clk) begin
      if (rst) begin
        q.delete();
        m_busy <= 1'b0;
        m_cnt  <= 0;
      end else if (en) begin
        if (m_busy && m_cnt == T) begin
          m_busy <= 1'b0;
          run_end_checks();
        end else if (m_busy) begin
          m_cnt <= m_cnt + 1;
        end else if (start) begin
          m_busy <= 1'b1;
          m_cnt  <= 1;
          push_transform();
        end
      end
    end

    // Monitor: control, freeze, scoreboard and coverage checks.
    always @(negedge clk) begin
      snap = 64'({busy, done, theta, aa, ab, stg, av, lb});
      if (rst) begin
        hist.delete();
        have_prev = 1'b0;
      end else begin
        if (have_prev && !prev_en && snap != prev_snap) frz_err++;
        prev_snap = snap;
        prev_en   = en;
        have_prev = 1'b1;
        if (busy != m_busy) ctl_err++;
        if (done != (m_busy && m_cnt == T)) ctl_err++;
        if (en) begin
          hist.push_back(int'(theta));
          if (hist.size() > L) begin
            th = hist.pop_front();
            if (av) begin
              if (q.size() == 0) sb_err++;
              else begin
                e = q.pop_front();
                if (e.first) begin
                  foreach (cov[i, j]) cov[i][j] = 1'b0;
                  vcount = 0; cov_total = 0; max_th0 = 0;
                end
                if (int'(aa) != e.a || int'(ab) != e.b || int'(stg) != e.s ||
                    lb != e.last || th != e.theta) sb_err++;
                vcount++;
                if (aa >= ab) ab_err++;
                if (int'(stg) < B) begin
                  if (cov[stg][aa]) dup_err++;
                  else begin cov[stg][aa] = 1'b1; cov_total++; end
                  if (cov[stg][ab]) dup_err++;
                  else begin cov[stg][ab] = 1'b1; cov_total++; end
                end
                if (stg == 4'd0 && th > max_th0) max_th0 = th;
              end
            end else if (th != 0 || lb) idle_err++;
          end
        end
      end
    end

    task automatic cyc();
      @(posedge clk);
      #1;
    endtask

    task automatic run_to_done(input int stall_at, input bit rnd, output int n);
      start = 1'b1; en = 1'b1;
      cyc();
      start = 1'b0;
      n = 1;
      while (!done && n < LIM) begin
        if (rnd) en = ($urandom_range(0, 3) != 0);
        else     en = !(n >= stall_at && n < stall_at + 5);
        cyc();
        n++;
      end
      en = 1'b1;
      if (!done) chk("done_timeout", gi, 0, 1);
    endtask

    // Stimulus sequence for this configuration.
    initial begin
      int n, m;
      rst = 1'b1; en = 1'b0; start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", gi, longint'({busy, done, theta, aa, ab, stg, av, lb}), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int r = 0; r < NRUNS; r++) begin
        en = 1'b1;
        repeat ($urandom_range(1, 4)) cyc();
        case (r)
          0: begin
            run_to_done(-100, 1'b0, n);
            chk("start_to_done", gi, n, T);
          end
          1: begin
            run_to_done(HALF + G + 2, 1'b0, n);
            chk("start_to_done_stall5", gi, n, T + 5);
          end
          2: begin
            run_to_done(-100, 1'b1, n);
            chk("done_seen_random_en", gi, int'(done), 1);
          end
          3: begin
            start = 1'b1;
            cyc();
            n = 1;
            while (!done && n < LIM) begin cyc(); n++; end
            chk("start_to_done_held", gi, n, T);
            m = 0;
            cyc(); m++;
            cyc(); m++;
            start = 1'b0;
            while (!done && m < LIM) begin cyc(); m++; end
            chk("rerun_from_held_start", gi, m, T + 1);
          end
          default: begin
            start = 1'b1;
            cyc();
            start = 1'b0;
            repeat (HALF + G + 1) cyc();
            rst = 1'b1;
            @(negedge clk);
            chk("reset_midrun_outputs", gi, longint'({busy, done, theta, aa, ab, stg, av, lb}), 0);
            repeat (2) cyc();
            rst = 1'b0;
            cyc();
            run_to_done(-100, 1'b0, n);
            chk("start_to_done_after_reset", gi, n, T);
          end
        endcase
        en = 1'b1;
        cyc();
      end
      repeat (L + 4) cyc();
      chk("busy_done_errors", gi, ctl_err, 0);
      chk("scoreboard_errors", gi, sb_err, 0);
      chk("freeze_errors", gi, frz_err, 0);
      chk("idle_slot_errors", gi, idle_err, 0);
      chk("a_below_b_errors", gi, ab_err, 0);
      chk("duplicate_addr_errors", gi, dup_err, 0);
      chk("queue_empty_final", gi, q.size(), 0);
      fin = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 90000 && !(g[0].fin && g[1].fin && g[2].fin && g[3].fin); c++)
      @(posedge clk);
    if (!(g[0].fin && g[1].fin && g[2].fin && g[3].fin)) chk("global_timeout", -1, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
